ac97_cmd_sequencer: RTL
=======================

# ac97_cmd_sequencer

Sequences AC97 codec register writes after the codec is out of reset. Once `audio_ready` and the codec's ready flag are both high and a settle delay has elapsed, it issues a fixed five-entry initialisation table over a valid/taken command handshake to the AC97 link block, then raises `config_done`. With runtime volume updates compiled in, it also issues master-volume writes on request. Sits between the codec reset block and the AC97 frame/link serializer.

## Interface
- SETTLE_CYCLES, 1024: clk cycles to wait after both ready inputs are high before the first command (≥1).
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- audio_ready  in  1  codec reset sequence complete (HOLD state of the reset block).
- codec_ready  in  1  codec-ready bit from slot 0 of the incoming AC97 frame.
- cmd_taken  in  1  link block accepted the current command this cycle.
- vol_req  in  1  single-cycle request for a master-volume write (AUDIO_VOL_UPDATE_EN only).
- vol_att  in  5  attenuation, 1.5 dB/step, applied to left and right.
- vol_mute  in  1  mute bit for the volume write.
- cmd_valid  out  1  `cmd_addr`/`cmd_data` are valid.
- cmd_addr  out  7  codec register address.
- cmd_data  out  16  codec register write data.
- config_done  out  1  initialisation table fully written.

## Operation
- States: WAIT_READY, SETTLE, ISSUE, GAP, RUN.
- **WAIT_READY:** `cmd_valid=0`, table index=0. Leaves for SETTLE when `audio_ready && codec_ready`; settle counter loads 0.
- **SETTLE:** counter increments each cycle. When it equals SETTLE_CYCLES-1, the next state is ISSUE with index 0.
- **ISSUE:** `cmd_valid=1`, addr/data driven from the table (or from the volume holder) and stable until taken. On `cmd_taken`, go to GAP.
- **GAP:** exactly one cycle with `cmd_valid=0`. Next state:
  - ISSUE with index+1 if the table is not finished;
  - otherwise ISSUE with the pending volume write, if one is pending;
  - otherwise RUN.
- **RUN:** `config_done=1`, `cmd_valid=0`. A pending volume write sends RUN to ISSUE.
- Init table, in issue order (addr → data):
  - 0x02 → 0x0000 (master, 0 dB)
  - 0x04 → 0x0000 (headphone)
  - 0x18 → 0x0808 (PCM out)
  - 0x1A → 0x0000 (record select mic)
  - 0x1C → 0x0F0F (record gain)
- `config_done` rises in the GAP cycle after the fifth `cmd_taken` and stays high in RUN and during later volume writes.
- Volume data = {vol_mute, 2'b00, vol_att, 3'b000, vol_att}, addr 0x02.
- Loss of readiness: if `audio_ready` or `codec_ready` is low in any state other than WAIT_READY, the next state is WAIT_READY. In the same cycle the block clears `cmd_valid`, `config_done` and the index. A pending volume request is kept.
- `cmd_taken` while `cmd_valid=0` is ignored.

## Timing
- Reset values: `cmd_valid=0`, `cmd_addr=0`, `cmd_data=0`, `config_done=0`, state WAIT_READY, nothing pending.
- Ready inputs high at cycle N → SETTLE from N+1 → `cmd_valid=1` at cycle N+1+SETTLE_CYCLES.
- `cmd_taken` at cycle T → `cmd_valid=0` at T+1 → next command valid at T+2.
- Minimum is 2 cycles per command. There is no upper bound; the block waits indefinitely for `cmd_taken`.
- A `vol_req` sets pending and captures att/mute at the next edge.
  - A later `vol_req` before issue overwrites the captured value (last wins).
  - A `vol_req` in the same cycle as `cmd_taken` of a volume write starts a new pending write.
- A volume write never preempts the init table. It is issued only after entry 4 is taken.
- Widths: the settle counter is clog2(SETTLE_CYCLES)+1 bits; the index is 3 bits and saturates at 5.

## Configuration
- `AUDIO_VOL_UPDATE_EN` defined: volume holder and pending logic are present; `vol_req`/`vol_att`/`vol_mute` behave as described.
- Not defined:
  - `vol_*` inputs are ignored.
  - No pending register is synthesized.
  - RUN is terminal until readiness is lost or reset.
  - Ports remain for a stable interface.

## Test plan
- Reset, then ready inputs high at cycle 10 with SETTLE_CYCLES=4 → `cmd_valid` at cycle 15 with addr 0x02/data 0x0000; all outputs 0 before.
- `cmd_taken` on each cycle `cmd_valid` is high → five commands in table order, valid every 2 cycles; `config_done` high one cycle after the fifth take.
- `cmd_taken` held off 50 cycles on entry 2 → addr 0x18/data 0x0808 stable throughout; no skip.
- Volume feature (`AUDIO_VOL_UPDATE_EN`): `vol_req` with att=5, mute=0 during entry 1, then att=9, mute=1 before the table ends → exactly one extra write after entry 4: addr 0x02, data 0x8909.
- `codec_ready` dropped for one cycle in RUN → `config_done` and `cmd_valid` low next cycle; on return, settle plus the full table repeats.
- `rst_n` low mid-ISSUE → all outputs 0 the next cycle; a pending volume request is cleared.

Source files
------------

// File: rtl/ac97_cmd_sequencer.sv
// Issues the AC97 codec initialisation writes over a valid/taken handshake once the codec is ready.
// Optional runtime master-volume writes are compiled in with `define AUDIO_VOL_UPDATE_EN.
module ac97_cmd_sequencer #(
   parameter int SETTLE_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        audio_ready,
   input  logic        codec_ready,
   input  logic        cmd_taken,
   input  logic        vol_req,
   input  logic [4:0]  vol_att,
   input  logic        vol_mute,
   output logic        cmd_valid,
   output logic [6:0]  cmd_addr,
   output logic [15:0] cmd_data,
   output logic        config_done
);

   localparam int CW = $clog2(SETTLE_CYCLES) + 1;
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [2:0] TABLE_LEN = 3'd5;

   typedef enum logic [2:0] {WAIT_READY, SETTLE, ISSUE, GAP, RUN} state_t;

   typedef struct packed {
      logic [6:0]  addr;
      logic [15:0] data;
   } cmd_t;

   function automatic cmd_t table_entry(input logic [2:0] idx);
      case (idx)
         3'd0:    table_entry = '{addr: 7'h02, data: 16'h0000};
         3'd1:    table_entry = '{addr: 7'h04, data: 16'h0000};
         3'd2:    table_entry = '{addr: 7'h18, data: 16'h0808};
         3'd3:    table_entry = '{addr: 7'h1A, data: 16'h0000};
         3'd4:    table_entry = '{addr: 7'h1C, data: 16'h0F0F};
         default: table_entry = '0;
      endcase
   endfunction

   state_t         state, state_nxt;
   logic [CW-1:0]  settle_cnt, settle_cnt_nxt;
   logic [2:0]     index, index_nxt;
   logic           vol_active, vol_active_nxt;
   logic [6:0]     addr_nxt;
   logic [15:0]    data_nxt;
   logic           ready;
   logic           load_vol;
   logic           pending;
   logic [15:0]    vol_word;
   cmd_t           entry;

   assign ready = audio_ready & codec_ready;
   assign entry = table_entry(index);

   // NOTE: every signal gets its default before the case so no path leaves a value unassigned (no latches).
   always_comb begin
      state_nxt      = state;
      settle_cnt_nxt = settle_cnt;
      index_nxt      = index;
      vol_active_nxt = vol_active;
      addr_nxt       = cmd_addr;
      data_nxt       = cmd_data;
      load_vol       = 1'b0;

      case (state)
         WAIT_READY: begin
            index_nxt      = '0;
            vol_active_nxt = 1'b0;
            if (ready) begin
               state_nxt      = SETTLE;
               settle_cnt_nxt = '0;
            end
         end
         SETTLE: begin
            settle_cnt_nxt = settle_cnt + 1'b1;
            if (settle_cnt == SETTLE_LAST) begin
               state_nxt      = ISSUE;
               index_nxt      = '0;
               vol_active_nxt = 1'b0;
               {addr_nxt, data_nxt} = table_entry(3'd0);
            end
         end
         ISSUE: begin
            if (cmd_taken) begin
               state_nxt = GAP;
               if (!vol_active && index < TABLE_LEN) index_nxt = index + 3'd1;
            end
         end
         GAP: begin
            if (index < TABLE_LEN) begin
               state_nxt      = ISSUE;
               vol_active_nxt = 1'b0;
               addr_nxt       = entry.addr;
               data_nxt       = entry.data;
            end else if (pending) begin
               state_nxt      = ISSUE;
               vol_active_nxt = 1'b1;
               load_vol       = 1'b1;
               addr_nxt       = 7'h02;
               data_nxt       = vol_word;
            end else begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (pending) begin
               state_nxt      = ISSUE;
               vol_active_nxt = 1'b1;
               load_vol       = 1'b1;
               addr_nxt       = 7'h02;
               data_nxt       = vol_word;
            end
         end
         default: state_nxt = WAIT_READY;
      endcase

      // Losing either ready input overrides everything and restarts the whole sequence.
      if (!ready && state != WAIT_READY) begin
         state_nxt      = WAIT_READY;
         index_nxt      = '0;
         vol_active_nxt = 1'b0;
         load_vol       = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= WAIT_READY;
         settle_cnt <= '0;
         index      <= '0;
         vol_active <= 1'b0;
         cmd_addr   <= '0;
         cmd_data   <= '0;
      end else begin
         state      <= state_nxt;
         settle_cnt <= settle_cnt_nxt;
         index      <= index_nxt;
         vol_active <= vol_active_nxt;
         cmd_addr   <= addr_nxt;
         cmd_data   <= data_nxt;
      end
   end

   assign cmd_valid   = (state == ISSUE);
   assign config_done = (index == TABLE_LEN);

`ifdef AUDIO_VOL_UPDATE_EN
   logic [4:0] att_q;
   logic       mute_q;
   logic       requeue;

   // An in-flight volume write cut short by readiness loss goes back to pending.
   assign requeue = (state == ISSUE) && vol_active && !ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending <= 1'b0;
         att_q   <= '0;
         mute_q  <= 1'b0;
      end else if (vol_req) begin
         pending <= 1'b1;
         att_q   <= vol_att;
         mute_q  <= vol_mute;
      end else if (load_vol) begin
         pending <= 1'b0;
      end else if (requeue) begin
         pending <= 1'b1;
      end
   end

   assign vol_word = {mute_q, 2'b00, att_q, 3'b000, att_q};
`else
   logic unused_vol;

   assign pending    = 1'b0;
   assign vol_word   = '0;
   assign unused_vol = ^{vol_req, vol_att, vol_mute, load_vol};
`endif

endmodule
